// File: rtl/fifo_wr_skid_if.sv
// Upstream valid/ready stream into the FIFO write-side skid front end.
// The producer drives data/valid and sees a registered ready.
interface fifo_wr_skid_if #(
  parameter int C_WIDTH = 32
);
  logic [C_WIDTH-1:0] S_DATA;
  logic               S_VALID;
  logic               S_READY;

  modport master (
    output S_DATA,
    output S_VALID,
    input  S_READY
  );

  modport slave (
    input  S_DATA,
    input  S_VALID,
    output S_READY
  );
endinterface

// File: rtl/fifo_wr_skid.sv
// Write-side skid front end: valid/ready stream in, FIFO write port out.
// Two-entry buffer keeps S_READY registered while WR_FULL throttles.
module fifo_wr_skid #(
  parameter int C_WIDTH     = 32,
  parameter int C_CNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  fifo_wr_skid_if.slave          s,
  output logic [C_WIDTH-1:0]     WR_DATA,
  output logic                   WR_EN,
  input  logic                   WR_FULL,
  output logic [1:0]             OCCUPANCY,
  output logic [C_CNT_WIDTH-1:0] WR_CNT
);

  logic [C_WIDTH-1:0]     main_data;
  logic                   main_valid;
  logic [C_WIDTH-1:0]     skid_data;
  logic                   skid_valid;
  logic                   skid_valid_nxt;
  logic                   ready_q;
  logic [C_CNT_WIDTH-1:0] cnt_q;
  logic                   accept;
  logic                   drain;

  assign accept = s.S_VALID & ready_q;
  assign drain  = main_valid & ~WR_FULL;

  assign s.S_READY = ready_q;
  assign WR_DATA   = main_data;
  assign WR_EN     = drain;
  assign OCCUPANCY = {1'b0, main_valid} + {1'b0, skid_valid};
  assign WR_CNT    = cnt_q;

  // A drain always empties the skid; it only fills when main is stuck.
  always_comb begin
    skid_valid_nxt = skid_valid;
    if (drain)
      skid_valid_nxt = 1'b0;
    else if (accept && main_valid)
      skid_valid_nxt = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      main_data  <= '0;
      main_valid <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      skid_valid <= skid_valid_nxt;
      ready_q    <= ~skid_valid_nxt;
      if (accept)
        cnt_q <= cnt_q + 1'b1;
      if (drain) begin
        if (skid_valid) begin
          main_data <= skid_data;
        end else if (accept) begin
          main_data <= s.S_DATA;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        if (!main_valid) begin
          main_data  <= s.S_DATA;
          main_valid <= 1'b1;
        end else begin
          skid_data <= s.S_DATA;
        end
      end
    end
  end

endmodule
